// File: rtl/timing_fsm.sv
// Per-bank DRAM timing tracker: one state machine and down-counter
// per bank group/bank pair, driven by one-hot command strobes.
module timing_fsm #(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int T_RCD   = 17,
  parameter int T_WR    = 14,
  parameter int T_RP    = 17,
  parameter int T_RFC   = 34,
  parameter int BL      = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] bg,
  input  logic [(BAWIDTH > 0 ? BAWIDTH : 1)-1:0] ba,
  input  logic ACT,
  input  logic BST,
  input  logic CFG,
  input  logic CKEH,
  input  logic CKEL,
  input  logic DPD,
  input  logic DPDX,
  input  logic MRR,
  input  logic MRW,
  input  logic PD,
  input  logic PDX,
  input  logic PR,
  input  logic PRA,
  input  logic RD,
  input  logic RDA,
  input  logic REF,
  input  logic SRF,
  input  logic WR,
  input  logic WRA,
  output logic [4:0] BankFSM [2**BGWIDTH][2**BAWIDTH]
);

  localparam int NBG = 2**BGWIDTH;
  localparam int NBA = 2**BAWIDTH;

  localparam int M_A = (T_RCD - 1 > T_WR) ? T_RCD - 1 : T_WR;
  localparam int M_B = (T_RP > T_RFC) ? T_RP - 1 : T_RFC - 1;
  localparam int M_C = (M_A > M_B) ? M_A : M_B;
  localparam int MAXV = (M_C > BL) ? M_C : BL;
  localparam int CW = (MAXV < 2) ? 1 : $clog2(MAXV + 1);

  localparam logic [CW-1:0] L_RCD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] L_WR  = CW'(T_WR);
  localparam logic [CW-1:0] L_BL  = CW'(BL);
  localparam logic [CW-1:0] L_RP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] L_RFC = CW'(T_RFC - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [4:0] {
    IDLE        = 5'h00,
    ACTIVATING  = 5'h01,
    ACTIVE      = 5'h03,
    PRECHARGING = 5'h0a,
    READING     = 5'h0b,
    READING_AP  = 5'h0c,
    REFRESHING  = 5'h0d,
    WRITING     = 5'h12,
    WRITING_AP  = 5'h13,
    ROWCLONE    = 5'h14
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_PRA, C_REF, C_PR, C_ACT,
    C_WRA, C_WR, C_RDA, C_RD
  } cmd_t;

  state_t        r_state [NBG][NBA];
  state_t        w_next  [NBG][NBA];
  logic [CW-1:0] r_cnt   [NBG][NBA];
  logic [CW-1:0] w_cnt   [NBG][NBA];
  logic          w_hit   [NBG][NBA];
  cmd_t          w_cmd;
  logic          w_unused;

  // These strobes never change bank state.
  assign w_unused = ^{BST, CFG, CKEH, CKEL, DPD, DPDX,
                      MRR, MRW, PD, PDX, SRF};

  always_comb begin
    w_cmd = C_NONE;
    if (PRA)      w_cmd = C_PRA;
    else if (REF) w_cmd = C_REF;
    else if (PR)  w_cmd = C_PR;
    else if (ACT) w_cmd = C_ACT;
    else if (WRA) w_cmd = C_WRA;
    else if (WR)  w_cmd = C_WR;
    else if (RDA) w_cmd = C_RDA;
    else if (RD)  w_cmd = C_RD;
  end

  always_comb begin
    for (int g = 0; g < NBG; g++) begin
      for (int b = 0; b < NBA; b++) begin
        w_hit[g][b] = (BGWIDTH == 0 || int'(bg) == g) &&
                      (BAWIDTH == 0 || int'(ba) == b);
      end
    end
  end

  always_comb begin
    for (int g = 0; g < NBG; g++) begin
      for (int b = 0; b < NBA; b++) begin
        w_next[g][b] = r_state[g][b];
        w_cnt[g][b]  = r_cnt[g][b];
        unique case (r_state[g][b])
          IDLE: begin
            if (w_hit[g][b] && w_cmd == C_ACT) begin
              w_next[g][b] = ACTIVATING;
              w_cnt[g][b]  = L_RCD;
            end else if (w_hit[g][b] && w_cmd == C_REF) begin
              w_next[g][b] = REFRESHING;
              w_cnt[g][b]  = L_RFC;
            end
          end
          ACTIVATING, ROWCLONE: begin
            if (r_cnt[g][b] == '0) w_next[g][b] = ACTIVE;
            else w_cnt[g][b] = r_cnt[g][b] - ONE;
          end
          ACTIVE, READING, WRITING: begin
            if (w_cmd == C_PRA) begin
              w_next[g][b] = PRECHARGING;
              w_cnt[g][b]  = L_RP;
            end else if (w_hit[g][b]) begin
              unique case (w_cmd)
                C_ACT: begin
                  // Row clone is only legal from ACTIVE.
                  if (r_state[g][b] == ACTIVE) begin
                    w_next[g][b] = ROWCLONE;
                    w_cnt[g][b]  = L_RCD;
                  end
                end
                C_RD:  w_next[g][b] = READING;
                C_WR:  w_next[g][b] = WRITING;
                C_RDA: begin
                  w_next[g][b] = READING_AP;
                  w_cnt[g][b]  = L_BL;
                end
                C_WRA: begin
                  w_next[g][b] = WRITING_AP;
                  w_cnt[g][b]  = L_WR;
                end
                C_PR: begin
                  w_next[g][b] = PRECHARGING;
                  w_cnt[g][b]  = L_RP;
                end
                default: ;
              endcase
            end
          end
          READING_AP, WRITING_AP: begin
            if (r_cnt[g][b] == '0) begin
              w_next[g][b] = PRECHARGING;
              w_cnt[g][b]  = L_RP;
            end else begin
              w_cnt[g][b] = r_cnt[g][b] - ONE;
            end
          end
          PRECHARGING, REFRESHING: begin
            if (r_cnt[g][b] == '0) w_next[g][b] = IDLE;
            else w_cnt[g][b] = r_cnt[g][b] - ONE;
          end
          default: begin
            w_next[g][b] = IDLE;
            w_cnt[g][b]  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int g = 0; g < NBG; g++) begin
        for (int b = 0; b < NBA; b++) begin
          r_state[g][b] <= IDLE;
          r_cnt[g][b]   <= '0;
        end
      end
    end else begin
      for (int g = 0; g < NBG; g++) begin
        for (int b = 0; b < NBA; b++) begin
          r_state[g][b] <= w_next[g][b];
          r_cnt[g][b]   <= w_cnt[g][b];
        end
      end
    end
  end

  always_comb begin
    for (int g = 0; g < NBG; g++) begin
      for (int b = 0; b < NBA; b++) begin
        BankFSM[g][b] = r_state[g][b];
      end
    end
  end

endmodule

// File: tb/tb_timing_fsm.sv
// Directed bench for timing_fsm: walks one bank through every state
// path and checks all 16 bank outputs at each step.
module tb_timing_fsm;

  localparam int T_RCD = 17;
  localparam int T_WR  = 14;
  localparam int T_RP  = 17;
  localparam int T_RFC = 34;
  localparam int BL    = 8;

  localparam logic [18:0] M_ACT = 19'd1 << 0;
  localparam logic [18:0] M_BST = 19'd1 << 1;
  localparam logic [18:0] M_CFG = 19'd1 << 2;
  localparam logic [18:0] M_PD  = 19'd1 << 9;
  localparam logic [18:0] M_PR  = 19'd1 << 11;
  localparam logic [18:0] M_PRA = 19'd1 << 12;
  localparam logic [18:0] M_RD  = 19'd1 << 13;
  localparam logic [18:0] M_RDA = 19'd1 << 14;
  localparam logic [18:0] M_REF = 19'd1 << 15;
  localparam logic [18:0] M_SRF = 19'd1 << 16;
  localparam logic [18:0] M_WR  = 19'd1 << 17;
  localparam logic [18:0] M_WRA = 19'd1 << 18;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic [18:0] strb;
  logic [4:0]  fsm [4][4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timing_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bg      (bg),
    .ba      (ba),
    .ACT     (strb[0]),
    .BST     (strb[1]),
    .CFG     (strb[2]),
    .CKEH    (strb[3]),
    .CKEL    (strb[4]),
    .DPD     (strb[5]),
    .DPDX    (strb[6]),
    .MRR     (strb[7]),
    .MRW     (strb[8]),
    .PD      (strb[9]),
    .PDX     (strb[10]),
    .PR      (strb[11]),
    .PRA     (strb[12]),
    .RD      (strb[13]),
    .RDA     (strb[14]),
    .REF     (strb[15]),
    .SRF     (strb[16]),
    .WR      (strb[17]),
    .WRA     (strb[18]),
    .BankFSM (fsm)
  );

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [18:0] s, input int g, input int b);
    bg   = 2'(g);
    ba   = 2'(b);
    strb = s;
    @(posedge clk);
    #1;
    strb = '0;
  endtask

  // Banks (g1,b1) and (g2,b2) expect e1/e2; every other bank expects IDLE.
  task automatic chk_all(input string tag,
                         input int g1, input int b1, input logic [4:0] e1,
                         input int g2, input int b2, input logic [4:0] e2);
    logic [4:0] exp;
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        if (g == g1 && b == b1) exp = e1;
        else if (g == g2 && b == b2) exp = e2;
        else exp = 5'h00;
        checks++;
        assert (fsm[g][b] === exp) else begin
          errors++;
          $error("FAIL %s bank(%0d,%0d) observed=%h expected=%h",
                 tag, g, b, fsm[g][b], exp);
        end
      end
    end
  endtask

  task automatic chk1(input string tag, input logic [4:0] e);
    chk_all(tag, 1, 1, e, -1, -1, 5'h00);
  endtask

  initial begin
    reset_n = 1'b1;
    bg      = '0;
    ba      = '0;
    strb    = '0;
    #2;
    chk1("reset", 5'h00);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;

    go(M_BST | M_CFG | M_PD | M_SRF, 1, 1);
    chk1("ignored_strobes", 5'h00);
    go(M_RD, 1, 1);
    chk1("rd_in_idle", 5'h00);

    go(M_ACT, 1, 1);
    chk1("act", 5'h01);
    go(M_RD, 1, 1);
    ticks(T_RCD - 2);
    chk1("activating_hold", 5'h01);
    ticks(1);
    chk1("active", 5'h03);

    go(M_WR, 1, 1);
    chk1("wr", 5'h12);
    ticks(15);
    chk1("wr_hold", 5'h12);
    go(M_RD, 1, 1);
    chk1("rd", 5'h0b);
    go(M_WR | M_RD, 1, 1);
    chk1("wr_over_rd", 5'h12);
    go(M_RD, 0, 2);
    chk1("rd_other_bank", 5'h12);
    go(M_PR | M_WR, 1, 1);
    chk1("pr", 5'h0a);
    go(M_ACT, 1, 1);
    ticks(T_RP - 2);
    chk1("pr_hold", 5'h0a);
    ticks(1);
    chk1("pr_done", 5'h00);

    go(M_REF | M_ACT, 1, 1);
    chk1("ref", 5'h0d);
    ticks(T_RFC - 1);
    chk1("ref_hold", 5'h0d);
    ticks(1);
    chk1("ref_done", 5'h00);

    go(M_ACT, 1, 1);
    ticks(T_RCD);
    chk1("active2", 5'h03);
    go(M_WRA, 1, 1);
    chk1("wra", 5'h13);
    ticks(T_WR);
    chk1("wra_hold", 5'h13);
    ticks(1);
    chk1("wra_pre", 5'h0a);
    ticks(T_RP - 1);
    chk1("wra_pre_hold", 5'h0a);
    ticks(1);
    chk1("wra_idle", 5'h00);

    go(M_ACT, 1, 1);
    ticks(T_RCD);
    chk1("active3", 5'h03);
    go(M_ACT, 1, 1);
    chk1("rowclone", 5'h14);
    ticks(T_RCD - 1);
    chk1("rowclone_hold", 5'h14);
    ticks(1);
    chk1("rowclone_done", 5'h03);
    go(M_RDA | M_RD, 1, 1);
    chk1("rda", 5'h0c);
    ticks(BL);
    chk1("rda_hold", 5'h0c);
    ticks(1);
    chk1("rda_pre", 5'h0a);
    ticks(T_RP);
    chk1("rda_idle", 5'h00);

    go(M_ACT, 2, 3);
    chk_all("act_23", 2, 3, 5'h01, -1, -1, 5'h00);
    reset_n = 1'b1;
    #1;
    chk_all("async_reset", -1, -1, 5'h00, -1, -1, 5'h00);
    #1;
    reset_n = 1'b0;

    go(M_ACT, 0, 1);
    chk_all("act_01", 0, 1, 5'h01, -1, -1, 5'h00);
    go(M_ACT, 3, 2);
    chk_all("act_32", 0, 1, 5'h01, 3, 2, 5'h01);
    ticks(T_RCD - 2);
    chk_all("both_act", 0, 1, 5'h01, 3, 2, 5'h01);
    ticks(1);
    chk_all("indep", 0, 1, 5'h03, 3, 2, 5'h01);
    ticks(1);
    chk_all("both_active", 0, 1, 5'h03, 3, 2, 5'h03);
    go(M_PRA | M_REF | M_ACT, 2, 2);
    chk_all("pra", 0, 1, 5'h0a, 3, 2, 5'h0a);
    ticks(T_RP);
    chk_all("pra_idle", -1, -1, 5'h00, -1, -1, 5'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
